// File: rtl/math_rf_if.sv
// Host-side byte bus of the math_rf unit: op/data in, selected byte and flags out.
interface math_rf_if;
   logic [7:0] data_in;
   logic [7:0] op_in;
   logic [7:0] data_out;
   logic       busy;
   logic       carry;

   modport master (output data_in, op_in, input data_out, busy, carry);
   modport slave  (input data_in, op_in, output data_out, busy, carry);
endinterface

// File: rtl/math_rf.sv
// Byte-serial math unit: NREGS accumulators of BITS bits, byte load/read through a
// shared pointer, add/sub/shift/move, and a fixed-latency shift-add multiplier.
module math_rf #(
   parameter int BITS  = 64,
   parameter int NREGS = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   math_rf_if.slave  bus
);
   localparam int NBYTES = BITS / 8;
   localparam int PTRW   = $clog2(NBYTES);
   localparam int RW     = (NREGS == 4) ? 2 : 1;
   localparam int CW     = $clog2(BITS + 1);

   localparam logic [3:0] OP_SETPTR = 4'h1, OP_CLR = 4'h2, OP_WRB  = 4'h3,
                          OP_SEL    = 4'h4, OP_NEXT = 4'h5, OP_ADDI = 4'h6,
                          OP_ADD    = 4'h7, OP_SUB = 4'h8, OP_SHL  = 4'h9,
                          OP_SHR    = 4'hA, OP_MUL = 4'hB, OP_MOV  = 4'hC;

   typedef enum logic {IDLE, MULT} state_t;
   state_t state, state_nxt;

   logic [NREGS-1:0][NBYTES-1:0][7:0] r;
   logic [PTRW-1:0] ptr, ptr_inc;
   logic [RW-1:0]   sel, dst, src, mdst;
   logic            carry_q;
   logic [BITS-1:0] ma, mb, mp, p_step, rd, rs;
   logic [CW-1:0]   cnt;
   logic [BITS:0]   add_res, addi_res;
   logic [3:0]      op;
   logic            last;

   // With NREGS=2 the register fields collapse to op bits [2] and [0].
   assign op  = bus.op_in[7:4];
   assign dst = bus.op_in[2 +: RW];
   assign src = bus.op_in[0 +: RW];
   assign rd  = r[dst];
   assign rs  = r[src];

   assign add_res  = {1'b0, rd} + {1'b0, rs};
   assign addi_res = {1'b0, rs} + {{(BITS-7){1'b0}}, bus.data_in};
   assign ptr_inc  = (ptr == PTRW'(NBYTES - 1)) ? '0 : ptr + PTRW'(1);
   assign p_step   = mp + (mb[0] ? ma : '0);
   assign last     = (cnt == CW'(1));

   assign bus.data_out = r[sel][ptr];
   assign bus.busy     = (state == MULT);
   assign bus.carry    = carry_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (op == OP_MUL) state_nxt = MULT;
         MULT:    if (last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r       <= '0;
         ptr     <= '0;
         sel     <= '0;
         carry_q <= 1'b0;
         ma      <= '0;
         mb      <= '0;
         mp      <= '0;
         cnt     <= '0;
         mdst    <= '0;
      end else if (state == MULT) begin
         // Host ops are dropped for the whole run, including the final edge.
         mp  <= p_step;
         ma  <= ma << 1;
         mb  <= mb >> 1;
         cnt <= cnt - CW'(1);
         if (last) r[mdst] <= p_step;
      end else begin
         case (op)
            OP_SETPTR: ptr <= bus.data_in[PTRW-1:0];
            OP_CLR:    r[dst] <= '0;
            OP_WRB: begin
               r[dst][ptr] <= bus.data_in;
               ptr         <= ptr_inc;
            end
            OP_SEL:    sel <= dst;
            OP_NEXT:   ptr <= ptr_inc;
            OP_ADDI: begin
               r[dst]  <= addi_res[BITS-1:0];
               carry_q <= addi_res[BITS];
            end
            OP_ADD: begin
               r[dst]  <= add_res[BITS-1:0];
               carry_q <= add_res[BITS];
            end
            OP_SUB: begin
               r[dst]  <= rd - rs;
               carry_q <= (rd < rs);
            end
            OP_SHL:    r[dst] <= rs << bus.data_in;
            OP_SHR:    r[dst] <= rs >> bus.data_in;
            OP_MUL: begin
               ma   <= rd;
               mb   <= rs;
               mp   <= '0;
               cnt  <= CW'(BITS);
               mdst <= dst;
            end
            OP_MOV:    r[dst] <= rs;
            default:   ;
         endcase
      end
   end
endmodule

// File: tb/tb_math_rf.sv
// Randomised and directed bench for math_rf against a value-level reference model.
module tb_math_rf;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   passes = 0;

   math_rf_if bus();
   math_rf #(.BITS(64), .NREGS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   always #5 clk = ~clk;

   // reference model state
   logic [63:0] m_r [4];
   int          m_ptr, m_sel, mrem, mdst;
   logic        m_carry;
   logic [63:0] mres;

   function automatic logic [7:0] exp_dout();
      return m_r[m_sel][m_ptr*8 +: 8];
   endfunction

   task automatic model_edge(input logic [7:0] op, input logic [7:0] d);
      int dd, ss;
      logic [64:0] t;
      dd = int'(op[3:2]);
      ss = int'(op[1:0]);
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) m_r[i] = '0;
         m_ptr = 0; m_sel = 0; m_carry = 1'b0; mrem = 0;
      end else if (mrem > 0) begin
         mrem--;
         if (mrem == 0) m_r[mdst] = mres;
      end else begin
         case (op[7:4])
            4'h1: m_ptr = int'(d) % 8;
            4'h2: m_r[dd] = '0;
            4'h3: begin m_r[dd][m_ptr*8 +: 8] = d; m_ptr = (m_ptr + 1) % 8; end
            4'h4: m_sel = dd;
            4'h5: m_ptr = (m_ptr + 1) % 8;
            4'h6: begin t = 65'(m_r[ss]) + 65'(d); m_r[dd] = t[63:0]; m_carry = t[64]; end
            4'h7: begin t = 65'(m_r[dd]) + 65'(m_r[ss]); m_r[dd] = t[63:0]; m_carry = t[64]; end
            4'h8: begin m_carry = (m_r[dd] < m_r[ss]); m_r[dd] = m_r[dd] - m_r[ss]; end
            4'h9: m_r[dd] = (d >= 64) ? 64'd0 : m_r[ss] << d;
            4'hA: m_r[dd] = (d >= 64) ? 64'd0 : m_r[ss] >> d;
            4'hB: begin mres = m_r[dd] * m_r[ss]; mdst = dd; mrem = 64; end
            4'hC: m_r[dd] = m_r[ss];
            default: ;
         endcase
      end
   endtask

   task automatic issue(input logic [7:0] op, input logic [7:0] d);
      bus.op_in   = op;
      bus.data_in = d;
      @(posedge clk);
      model_edge(op, d);
      #1;
   endtask

   task automatic set_reg(input int idx, input logic [63:0] v);
      issue(8'h10, 8'h00);
      for (int b = 0; b < 8; b++) issue({4'h3, 2'(idx), 2'b00}, v[b*8 +: 8]);
   endtask

   task automatic read_reg(input int idx, output logic [63:0] v);
      issue(8'h10, 8'h00);
      issue({4'h4, 2'(idx), 2'b00}, 8'h00);
      for (int b = 0; b < 8; b++) begin
         v[b*8 +: 8] = bus.data_out;
         issue(8'h50, 8'h00);
      end
   endtask

   task automatic wait_idle(input int limit, output int busy_cycles);
      busy_cycles = 0;
      while (bus.busy === 1'b1 && busy_cycles < limit) begin
         busy_cycles++;
         issue(8'h00, 8'h00);
      end
   endtask

   task automatic test_reset();
      logic [63:0] v;
      rst_n = 1'b0;
      repeat (3) issue(8'h00, 8'h00);
      checks++;
      if (bus.data_out !== 8'h00 || bus.busy !== 1'b0 || bus.carry !== 1'b0)
         $display("FAIL reset_outputs: dout=%h busy=%b carry=%b want 00/0/0",
                  bus.data_out, bus.busy, bus.carry);
      else passes++;
      rst_n = 1'b1;
      read_reg(3, v);
      checks++;
      if (v !== 64'd0) $display("FAIL reset_r3: got %h want 0", v);
      else passes++;
   endtask

   task automatic test_wrb_read();
      issue(8'h10, 8'h00);
      for (int k = 1; k <= 8; k++) issue(8'h34, 8'(8'h11 * k));
      issue(8'h44, 8'h00);
      for (int k = 1; k <= 9; k++) begin
         logic [7:0] want;
         want = (k == 9) ? 8'h11 : 8'(8'h11 * k);
         checks++;
         if (bus.data_out !== want || exp_dout() !== want)
            $display("FAIL wrb_byte%0d: got %h want %h", k, bus.data_out, want);
         else passes++;
         issue(8'h50, 8'h00);
      end
   endtask

   task automatic test_addi_carry();
      logic [63:0] v;
      set_reg(0, 64'hFFFF_FFFF_FFFF_FFFF);
      issue(8'h60, 8'h01);
      checks++;
      if (bus.carry !== 1'b1) $display("FAIL addi_carry: got %b want 1", bus.carry);
      else passes++;
      read_reg(0, v);
      checks++;
      if (v !== 64'd0) $display("FAIL addi_wrap: got %h want 0", v);
      else passes++;
      issue(8'hC8, 8'h00);
      checks++;
      if (bus.carry !== 1'b1) $display("FAIL mov_holds_carry: got %b want 1", bus.carry);
      else passes++;
   endtask

   task automatic test_sub();
      logic [63:0] v;
      set_reg(0, 64'd5);
      set_reg(1, 64'd7);
      issue(8'h81, 8'h00);
      checks++;
      if (bus.carry !== 1'b1) $display("FAIL sub_borrow: got %b want 1", bus.carry);
      else passes++;
      read_reg(0, v);
      checks++;
      if (v !== 64'hFFFF_FFFF_FFFF_FFFE || v !== m_r[0])
         $display("FAIL sub_value: got %h want FFFFFFFFFFFFFFFE", v);
      else passes++;
      issue(8'h24, 8'h00);
      issue(8'h81, 8'h00);
      checks++;
      if (bus.carry !== 1'b0) $display("FAIL sub_no_borrow: got %b want 0", bus.carry);
      else passes++;
   endtask

   task automatic test_mul();
      logic [63:0] v;
      int n;
      set_reg(2, 64'h1234);
      set_reg(3, 64'h100);
      issue(8'hBB, 8'h00);
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         n++;
         if (n == 10) issue(8'h38, 8'hAA);
         else issue(8'h00, 8'h00);
      end
      checks++;
      if (n !== 64) $display("FAIL mul_busy_cycles: got %0d want 64", n);
      else passes++;
      read_reg(2, v);
      checks++;
      if (v !== 64'h123400 || v !== m_r[2]) $display("FAIL mul_result: got %h want 123400", v);
      else passes++;
      issue(8'hBF, 8'h00);
      wait_idle(200, n);
      read_reg(3, v);
      checks++;
      if (v !== 64'h10000) $display("FAIL mul_square: got %h want 10000", v);
      else passes++;
   endtask

   task automatic test_shift();
      logic [63:0] v;
      set_reg(1, 64'hDEAD_BEEF_0123_4567);
      issue(8'h95, 8'd64);
      read_reg(1, v);
      checks++;
      if (v !== 64'd0) $display("FAIL shl_64: got %h want 0", v);
      else passes++;
      set_reg(1, 64'h8000_0000_0000_0001);
      issue(8'h95, 8'd200);
      read_reg(1, v);
      checks++;
      if (v !== 64'd0) $display("FAIL shl_200: got %h want 0", v);
      else passes++;
      set_reg(1, 64'hF0);
      issue(8'hA5, 8'd4);
      read_reg(1, v);
      checks++;
      if (v !== 64'h0F) $display("FAIL shr_4: got %h want 0f", v);
      else passes++;
   endtask

   task automatic test_reset_mid_mul();
      logic [63:0] v;
      set_reg(1, 64'h55);
      set_reg(2, 64'h77);
      issue(8'hB6, 8'h00);
      repeat (9) issue(8'h00, 8'h00);
      rst_n = 1'b0;
      issue(8'h00, 8'h00);
      rst_n = 1'b1;
      checks++;
      if (bus.busy !== 1'b0 || bus.data_out !== 8'h00)
         $display("FAIL reset_mid_mul: busy=%b dout=%h want 0/00", bus.busy, bus.data_out);
      else passes++;
      for (int i = 0; i < 4; i++) begin
         read_reg(i, v);
         checks++;
         if (v !== 64'd0) $display("FAIL reset_mid_mul_r%0d: got %h want 0", i, v);
         else passes++;
      end
      set_reg(2, 64'hCAFE);
      read_reg(2, v);
      checks++;
      if (v !== 64'hCAFE) $display("FAIL post_reset_write: got %h want cafe", v);
      else passes++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic [7:0] op, d;
         op = 8'($urandom);
         d  = (op[7:4] == 4'h9 || op[7:4] == 4'hA) ? 8'($urandom_range(0, 80)) : 8'($urandom);
         issue(op, d);
         checks++;
         if (bus.data_out !== exp_dout() || bus.busy !== (mrem > 0) || bus.carry !== m_carry)
            $display("FAIL random_%0d op=%h d=%h: dout=%h busy=%b carry=%b want %h/%b/%b",
                     i, op, d, bus.data_out, bus.busy, bus.carry,
                     exp_dout(), (mrem > 0), m_carry);
         else passes++;
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.op_in   = 8'h00;
      bus.data_in = 8'h00;
      for (int i = 0; i < 4; i++) m_r[i] = '0;
      m_ptr = 0; m_sel = 0; m_carry = 1'b0; mrem = 0; mdst = 0; mres = '0;
      test_reset();
      test_wrb_read();
      test_addi_carry();
      test_sub();
      test_mul();
      test_shift();
      test_reset_mid_mul();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/math_rf.md
Name: math_rf

Overview:
- Next-generation byte-serial math unit with a parametrised register file of NREGS accumulators, each BITS wide.
- Operands are loaded, and results read, one byte at a time through a shared byte pointer.
- Supports add/sub with carry flag, variable shifts, moves, and a multi-cycle shift-add multiplier with a busy indication.
- Sits between the 8-bit host data/op pins and nothing else; fully self-contained.

Parameters:
- BITS, 64, accumulator width; multiple of 8, range 16..128.
- NREGS, 4, number of accumulators; 2 or 4.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low; clock clk
- data_in  input  8  byte operand / immediate
- op_in  input  8  instruction: [7:4] opcode, [3:2] dst, [1:0] src (NREGS=2 uses bits [2] and [0] only)
- data_out  output  8  byte ptr of R[sel] (combinational from registers)
- busy  output  1  multiplier running; ops ignored
- carry  output  1  carry/borrow flag

Behaviour:
- Derived width: PTRW = clog2(BITS/8). State: R[0..NREGS-1], ptr (PTRW bits), sel, carry, multiplier state.
- Reset: all R = 0, ptr = 0, sel = 0, carry = 0, busy = 0, so data_out = 0. Reset mid-multiply aborts it; dst is not written.
- All ops execute at the clk edge on which they are presented. Single-cycle results are visible the next cycle.
- Opcodes:
  - 0 NOP.
  - 1 SETPTR: ptr <= data_in[PTRW-1:0].
  - 2 CLR: R[dst] <= 0.
  - 3 WRB: R[dst] byte[ptr] <= data_in; ptr <= ptr+1, wrapping from BITS/8-1 to 0.
  - 4 SEL: sel <= dst.
  - 5 NEXT: ptr <= ptr+1, same wrap.
  - 6 ADDI: R[dst] <= R[src] + zero-extended data_in; carry <= carry-out.
  - 7 ADD: R[dst] <= R[dst] + R[src]; carry <= carry-out.
  - 8 SUB: R[dst] <= R[dst] - R[src] mod 2^BITS; carry <= 1 iff R[dst] < R[src] (borrow).
  - 9 SHL: R[dst] <= R[src] << data_in; amount >= BITS yields 0.
  - A SHR: logical right shift, same rules as SHL.
  - B MUL: multi-cycle, see below.
  - C MOV: R[dst] <= R[src].
  - D-F: NOP.
- carry changes only on ADDI/ADD/SUB; all other ops hold it.
- dst == src is legal for every op; operands are read before the write (e.g. ADD r,r doubles r).
- MUL, issue edge T0:
  - Captures A = R[dst], B = R[src], P = 0, count = BITS.
  - busy = 1 from the cycle after T0.
  - Each edge: if B[0], P += A; then A <<= 1, B >>= 1, count--.
  - At edge T0+BITS: R[dst] <= low BITS bits of P, busy falls. Latency is fixed, no early exit.
  - While busy = 1, every op_in is ignored (not queued), including SETPTR/SEL/WRB. The op presented on edge T0+BITS is also ignored.
  - Reading via data_out during busy is allowed; R[dst] shows its old value until T0+BITS.
- Multiple source registers are never written on the same edge; only one op per cycle.

Test Plan:
- Reset, then WRB to R1 with ptr=0 and bytes 0x11..0x88 -> ptr wraps to 0; SEL 1 + 8x NEXT reads 0x11..0x88 on data_out, then back to 0x11.
- R0 = 0xFFFF_FFFF_FFFF_FFFF, ADDI R0,R0 with data_in=0x01 -> R0 = 0, carry = 1; subsequent MOV leaves carry = 1.
- R0 = 5, R1 = 7, SUB R0,R1 -> R0 = 0xFFFF_FFFF_FFFF_FFFE, carry = 1; SUB again with R1 = 0 -> carry = 0.
- R2 = 0x1234, R3 = 0x100, MUL R2,R3 -> busy high exactly 64 cycles. A WRB issued mid-run has no effect. R2 = 0x123400 after busy falls. MUL R3,R3 -> R3 = 0x10000.
- SHL R1,R1 with data_in=64 and with data_in=200 -> R1 = 0. SHR with data_in=4 on 0xF0 -> 0x0F.
- Start MUL, assert rst_n=0 at cycle 10 -> busy = 0, all R = 0, data_out = 0 next cycle; ops accepted immediately after reset release.
